seq_checker: RTL
================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter MAX_VAL, default 9, meaning: highest run value before the sequence wraps to 1 (legal range 2..15).
REQ-002 Parameter ERR_W, default 8, meaning: width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the in_data beat is present this cycle.
REQ-006 in_data  input  4  sequence value from the upstream generator.
REQ-007 clear  input  1  synchronous re-arm: return to HUNT and zero err_cnt.
REQ-008 locked  output  1  high while in LOCK.
REQ-009 exp_data  output  4  next value expected; 0 in HUNT.
REQ-010 run_done  output  1  one-cycle pulse when a run of value k repeated k times completes.
REQ-011 wrap  output  1  one-cycle pulse when the MAX_VAL run completes.
REQ-012 err  output  1  one-cycle pulse on a mismatching beat.
REQ-013 err_cnt  output  ERR_W  count of err pulses, saturating at all-ones.

Function
REQ-014 Legal stream: 1 once, 2 twice, 3 three times, ... MAX_VAL MAX_VAL times, then 1 again, repeating indefinitely.
REQ-015 FSM states: HUNT and LOCK only, held in registers exp_val (4b) and rep_cnt (4b).
REQ-016 HUNT: a valid beat with in_data==1 completes run 1; it pulses run_done, sets exp_val=2 and rep_cnt=0, and moves to LOCK.
REQ-017 HUNT: a valid beat with any other value is ignored, with no err pulse.
REQ-018 LOCK, matching beat (in_data==exp_val): rep_cnt increments.
REQ-019 LOCK, run completion (rep_cnt+1==exp_val): run_done pulses and rep_cnt is set to 0.
REQ-020 On run completion, exp_val advances by 1; if exp_val was MAX_VAL, exp_val becomes 1 and wrap pulses together with run_done.
REQ-021 LOCK, mismatching beat: err pulses, err_cnt increments (saturating), and the FSM moves to HUNT.
REQ-022 The mismatching beat is not reused for re-lock, even when its value is 1.
REQ-023 in_valid low: all state holds; pulses are not asserted; there is no timeout.
REQ-024 clear has priority over a simultaneous in_valid beat; that beat is discarded.
REQ-025 Latency: every output is registered; a pulse appears in the cycle after the clock edge that samples the causing beat.
REQ-026 locked and exp_data reflect the post-update state in that same cycle.
REQ-027 err_cnt holds at 2^ERR_W-1 once it saturates; only rst or clear zero it.

Reset
REQ-028 While rst is high: state=HUNT, exp_val=0, rep_cnt=0, err_cnt=0, and locked, run_done, wrap and err are all 0.
REQ-029 rst asserted mid-run discards the run in progress; after release, the checker requires a fresh 1 to lock.

Structure
REQ-030 Shared package seq_pkg holds: the state encoding (HUNT, LOCK), the MAX_VAL default, and the data width constant DATA_W=4, which is shared with the upstream generator.
REQ-031 A single sub-module sat_cnt (parameter width; ports inc and clr; saturating) implements err_cnt.
REQ-032 There are no other sub-modules.

Verification
REQ-033 Reset release, then beats 1,2,2,3,3,3: locked=1 from the first beat; run_done pulses 3 times; err=0; exp_data=4 at the end.
REQ-034 Full 45-beat sequence 1..9 followed by a 1: wrap pulses exactly once, with the 45th beat's run_done; exp_data=1, then 2 after the trailing 1; err=0.
REQ-035 Beats 1,2,3: err pulses on the third beat; err_cnt=1; locked=0; a following beat 1 re-locks.
REQ-036 In HUNT, beats 5,7,0 then 1: no err; locked rises only after the 1.
REQ-037 Beats 1,2 with 3 idle cycles, then 2: there is no error, exp_data holds 2 across the gap, and run_done pulses after the final 2.
REQ-038 rst asserted mid-run 3,3 -> all outputs 0; clear coincident with a valid 1 -> stays in HUNT; 300 mismatches -> err_cnt=255.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence checker and its upstream generator.
//   state_e     : checker FSM encoding (HUNT, LOCK)
//   DATA_W      : width of a sequence value
//   MAX_VAL_DEF : default highest run value before the stream wraps to 1
package seq_pkg;

   localparam int unsigned DATA_W      = 4;
   localparam int unsigned MAX_VAL_DEF = 9;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_e;

endpackage : seq_pkg

// File: rtl/sat_cnt.sv
// Saturating up-counter.
//   clk, rst : clock, async active-high reset
//   inc      : count up by one unless already at all-ones
//   clr      : synchronous clear, wins over inc
//   cnt      : registered count value
module sat_cnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;

   // Count register: hold at all-ones once saturated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt = cnt_q;

endmodule : sat_cnt

// File: rtl/seq_checker.sv
// Checks a stream of the form 1, 2,2, 3,3,3, ... MAX_VAL x MAX_VAL, then 1 again.
//   clk, rst  : clock, async active-high reset
//   in_valid  : in_data beat present
//   in_data   : sequence value
//   clear     : synchronous re-arm (back to HUNT, err_cnt zeroed)
//   locked    : checker is in LOCK
//   exp_data  : next value expected (0 in HUNT)
//   run_done  : pulse, a run of value k completed k beats
//   wrap      : pulse, the MAX_VAL run completed
//   err       : pulse, mismatching beat while locked
//   err_cnt   : saturating count of err pulses
module seq_checker
   import seq_pkg::*;
#(
   parameter int unsigned MAX_VAL = MAX_VAL_DEF,
   parameter int unsigned ERR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              clear,
   output logic              locked,
   output logic [DATA_W-1:0] exp_data,
   output logic              run_done,
   output logic              wrap,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VAL);
   localparam logic [DATA_W-1:0] ONE_V = DATA_W'(1);

   state_e            state_q;
   logic [DATA_W-1:0] exp_val_q;
   logic [DATA_W-1:0] rep_cnt_q;
   logic              run_done_q;
   logic              wrap_q;
   logic              err_q;

   logic beat_c;
   logic match_c;
   logic run_end_c;
   logic err_d;

   // Beat qualification; clear discards a coincident beat.
   assign beat_c    = in_valid && !clear;
   assign match_c   = (in_data == exp_val_q);
   assign run_end_c = ((rep_cnt_q + ONE_V) == exp_val_q);
   assign err_d     = beat_c && (state_q == LOCK) && !match_c;

   // Checker FSM with registered pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HUNT;
         exp_val_q  <= '0;
         rep_cnt_q  <= '0;
         run_done_q <= 1'b0;
         wrap_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         run_done_q <= 1'b0;
         wrap_q     <= 1'b0;
         err_q      <= 1'b0;
         if (clear) begin
            state_q   <= HUNT;
            exp_val_q <= '0;
            rep_cnt_q <= '0;
         end else if (in_valid) begin
            case (state_q)
               HUNT: begin
                  // A 1 is itself a complete run, so lock expecting 2.
                  if (in_data == ONE_V) begin
                     state_q    <= LOCK;
                     exp_val_q  <= DATA_W'(2);
                     rep_cnt_q  <= '0;
                     run_done_q <= 1'b1;
                  end
               end
               LOCK: begin
                  if (match_c) begin
                     if (run_end_c) begin
                        rep_cnt_q  <= '0;
                        run_done_q <= 1'b1;
                        if (exp_val_q == MAX_V) begin
                           exp_val_q <= ONE_V;
                           wrap_q    <= 1'b1;
                        end else begin
                           exp_val_q <= exp_val_q + ONE_V;
                        end
                     end else begin
                        rep_cnt_q <= rep_cnt_q + ONE_V;
                     end
                  end else begin
                     // Mismatch is consumed here; re-lock needs a later 1.
                     state_q   <= HUNT;
                     exp_val_q <= '0;
                     rep_cnt_q <= '0;
                     err_q     <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   sat_cnt #(
      .WIDTH (ERR_W)
   ) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (err_d),
      .clr (clear),
      .cnt (err_cnt)
   );

   assign locked   = (state_q == LOCK);
   assign exp_data = exp_val_q;
   assign run_done = run_done_q;
   assign wrap     = wrap_q;
   assign err      = err_q;

endmodule : seq_checker
